// File: rtl/sim_run_monitor.sv
// Run controller: watches committed PC, stops on end/limit/invalid/stuck,
// then walks reg_sel over the register file streaming values into a checksum.
module sim_run_monitor #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  END_PC      = XLEN'(32'h100),
  parameter int unsigned      MAX_CYCLES  = 1000,
  parameter int unsigned      STALL_LIMIT = 16,
  parameter int unsigned      NREG        = 32,
  parameter int unsigned      SEL_W       = 5,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_valid,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [XLEN-1:0]  reg_data,
  output logic             dump_valid,
  output logic [SEL_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic [XLEN-1:0]  checksum,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       halt_cause,
  output logic             done
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_END     = 3'd1;
  localparam logic [2:0] CAUSE_LIMIT   = 3'd2;
  localparam logic [2:0] CAUSE_INVALID = 3'd3;
  localparam logic [2:0] CAUSE_STUCK   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [XLEN-1:0]    checksum_q, checksum_d;
  logic [2:0]         halt_cause_q, halt_cause_d;
  logic [SEL_W-1:0]   reg_sel_q, reg_sel_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;

  logic       pc_same_c;
  logic       last_idx_c;
  logic [2:0] cause_c;
  logic       halt_c;

  assign pc_same_c  = (pc == last_pc_q);
  assign last_idx_c = (reg_sel_q == SEL_W'(NREG - 1));
  assign halt_c     = (cause_c != CAUSE_NONE);

  // Halt checks in priority order, using the pre-increment cycle count
  always_comb begin
    cause_c = CAUSE_NONE;
    if (!pc_valid)
      cause_c = CAUSE_INVALID;
    else if (pc == END_PC)
      cause_c = CAUSE_END;
    else if (pc_same_c && (stall_q == STALL_W'(STALL_LIMIT - 2)))
      cause_c = CAUSE_STUCK;
    else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1))
      cause_c = CAUSE_LIMIT;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start)      state_d = S_RUN;
      S_RUN:          if (halt_c)     state_d = S_DUMP;
      S_DUMP:         if (last_idx_c) state_d = S_DONE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Output decode and datapath next-state
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    checksum_d   = checksum_q;
    halt_cause_d = halt_cause_q;
    reg_sel_d    = reg_sel_q;
    stall_d      = stall_q;
    last_pc_d    = last_pc_q;
    dump_valid   = (state_q == S_DUMP);
    done         = (state_q == S_DONE);
    dump_idx     = dump_valid ? reg_sel_q : '0;
    dump_data    = dump_valid ? reg_data  : '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cycle_cnt_d  = '0;
          checksum_d   = '0;
          halt_cause_d = CAUSE_NONE;
          reg_sel_d    = '0;
          stall_d      = '0;
          last_pc_d    = pc;
        end
      end
      S_RUN: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        last_pc_d = pc;
        stall_d   = pc_same_c ? stall_q + STALL_W'(1) : '0;
        if (halt_c) begin
          halt_cause_d = cause_c;
          reg_sel_d    = '0;
        end
      end
      S_DUMP: begin
        checksum_d = {checksum_q[XLEN-2:0], checksum_q[XLEN-1]} ^ reg_data;
        reg_sel_d  = last_idx_c ? '0 : reg_sel_q + SEL_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt_q  <= '0;
      checksum_q   <= '0;
      halt_cause_q <= CAUSE_NONE;
      reg_sel_q    <= '0;
      stall_q      <= '0;
      last_pc_q    <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      checksum_q   <= checksum_d;
      halt_cause_q <= halt_cause_d;
      reg_sel_q    <= reg_sel_d;
      stall_q      <= stall_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign reg_sel    = reg_sel_q;
  assign checksum   = checksum_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign halt_cause = halt_cause_q;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Scoreboard bench for sim_run_monitor: per-run PC traces are scanned by a
// history-window reference model; a negedge monitor pops expected dumps/results.
module tb_sim_run_monitor;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 4;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CNT_W  = 32;
  localparam int          MAX_C  = 1000;
  localparam int          STALL  = 16;
  localparam logic [31:0] END_PC = 32'h100;

  typedef struct {
    logic [SEL_W-1:0] idx;
    logic [XLEN-1:0]  data;
  } dump_t;

  typedef struct {
    logic [2:0]       cause;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  csum;
  } result_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic [SEL_W-1:0] reg_sel;
  logic [XLEN-1:0]  reg_data;
  logic             dump_valid;
  logic [SEL_W-1:0] dump_idx;
  logic [XLEN-1:0]  dump_data;
  logic [XLEN-1:0]  checksum;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       halt_cause;
  logic             done;

  int checks = 0;
  int errors = 0;

  dump_t   dump_q[$];
  result_t res_q[$];

  logic [31:0] pcs    [MAX_C];
  logic        valids [MAX_C];
  logic [31:0] regs   [NREG];
  logic [31:0] start_pc;
  logic        done_prev = 1'b0;

  sim_run_monitor #(
    .XLEN(XLEN), .END_PC(END_PC), .MAX_CYCLES(MAX_C), .STALL_LIMIT(STALL),
    .NREG(NREG), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .pc(pc), .pc_valid(pc_valid),
    .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .checksum(checksum),
    .cycle_cnt(cycle_cnt), .halt_cause(halt_cause), .done(done)
  );

  always #5 clk = ~clk;

  // Register file read port model
  always_comb reg_data = (int'(reg_sel) < NREG) ? regs[reg_sel[1:0]] : '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_csum();
    logic [31:0] c = '0;
    for (int i = 0; i < NREG; i++) c = ((c << 1) | (c >> 31)) ^ regs[i];
    return c;
  endfunction

  // PC unchanged over the last STALL cycles (start PC counts as history)
  function automatic logic stuck_at(input int c);
    logic [31:0] prev;
    for (int k = 1; k < STALL; k++) begin
      if (c - k < -1) return 1'b0;
      prev = (c - k == -1) ? start_pc : pcs[c - k];
      if (prev != pcs[c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_halt(output int hc, output logic [2:0] cause);
    hc = MAX_C - 1;
    cause = 3'd2;
    for (int c = 0; c < MAX_C; c++) begin
      if (!valids[c])           begin hc = c; cause = 3'd3; break; end
      else if (pcs[c] == END_PC) begin hc = c; cause = 3'd1; break; end
      else if (stuck_at(c))      begin hc = c; cause = 3'd4; break; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_reg_sel"},    64'(reg_sel),    64'd0);
    chk({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_dump_idx"},   64'(dump_idx),   64'd0);
    chk({tag, "_dump_data"},  64'(dump_data),  64'd0);
    chk({tag, "_checksum"},   64'(checksum),   64'd0);
    chk({tag, "_cycle_cnt"},  64'(cycle_cnt),  64'd0);
    chk({tag, "_halt_cause"}, 64'(halt_cause), 64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
  endtask

  task automatic gen_directed(input int kind);
    start_pc = 32'hDEAD_0000;
    for (int i = 0; i < NREG; i++) regs[i] = 32'(i + 1);
    for (int c = 0; c < MAX_C; c++) begin
      valids[c] = 1'b1;
      unique case (kind)
        0: pcs[c] = 32'(4 * c);
        1: pcs[c] = 32'h1000 + 32'(4 * c);
        2: pcs[c] = (c < 10) ? 32'(4 * c) : 32'h40;
        3: pcs[c] = (c < 10) ? 32'(4 * c) : (c < 25) ? 32'h40 : END_PC;
        default: begin
          pcs[c] = (c < 5) ? 32'h300 + 32'(4 * c) : END_PC;
          valids[c] = (c != 5);
        end
      endcase
    end
  endtask

  task automatic gen_random();
    logic [31:0] p;
    int hold = 0;
    int r;
    start_pc = $urandom;
    p = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    for (int c = 0; c < MAX_C; c++) begin
      r = $urandom_range(0, 199);
      valids[c] = 1'b1;
      if (hold > 0) begin
        hold--;
        pcs[c] = p;
      end else if (r < 6) begin
        hold = $urandom_range(12, 17);
        pcs[c] = p;
      end else if (r < 8 && c > 30) begin
        pcs[c] = END_PC;
      end else if (r < 10 && c > 30) begin
        valids[c] = 1'b0;
        pcs[c] = $urandom;
      end else begin
        p = p + 32'd4;
        pcs[c] = p;
      end
    end
  endtask

  // Drives one run; abort_k >= 0 pulses reset at that dump cycle
  task automatic exec_run(input int abort_k);
    int hc;
    logic [2:0] cause;
    logic got = 1'b0;
    result_t res;
    dump_t d;
    model_halt(hc, cause);
    for (int i = 0; i < NREG; i++) begin
      d.idx = SEL_W'(i);
      d.data = regs[i];
      dump_q.push_back(d);
    end
    res.cause = cause;
    res.cnt = CNT_W'(hc + 1);
    res.csum = model_csum();
    res_q.push_back(res);

    @(posedge clk); #1;
    start = 1'b1; pc = start_pc; pc_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= hc; c++) begin
      pc = pcs[c]; pc_valid = valids[c];
      @(posedge clk); #1;
    end
    pc = $urandom; pc_valid = 1'($urandom);
    for (int k = 0; k < NREG + 4 && !got; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        dump_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if (done) begin
        got = 1'b1;
        chk("done_latency", 64'(k), 64'(NREG));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles of halt", NREG + 4);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    dump_t d;
    result_t r;
    if (rstn) begin
      if (dump_valid) begin
        if (dump_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dump: idx=%0d data=0x%0h", dump_idx, dump_data);
        end else begin
          d = dump_q.pop_front();
          chk("dump_idx",  64'(dump_idx),  64'(d.idx));
          chk("dump_data", 64'(dump_data), 64'(d.data));
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: cause=%0d cnt=%0d", halt_cause, cycle_cnt);
        end else begin
          r = res_q.pop_front();
          chk("halt_cause", 64'(halt_cause), 64'(r.cause));
          chk("cycle_cnt",  64'(cycle_cnt),  64'(r.cnt));
          chk("checksum",   64'(checksum),   64'(r.csum));
        end
      end
      done_prev <= done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  initial begin
    rstn = 1'b0; start = 1'b0; pc = '0; pc_valid = 1'b0;
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    #17;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int kind = 0; kind < 5; kind++) begin
      gen_directed(kind);
      exec_run(-1);
    end
    for (int n = 0; n < 10; n++) begin
      gen_random();
      exec_run(-1);
    end
    gen_random();
    exec_run(2);
    exec_run(-1);
    for (int n = 0; n < 4; n++) begin
      gen_random();
      exec_run(-1);
    end

    repeat (3) @(posedge clk);
    if (dump_q.size() != 0 || res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expected: dumps=%0d results=%0d", dump_q.size(), res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
